// File: rtl/uart_pkg.sv
// Shared types and constants for the ROM-to-UART message sender.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        START,
        DATA,
        STOP,
        FINISH
    } state_t;

    // start + 8 data + stop
    localparam int FRAME_BITS = 10;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// One 8N1 frame serialiser: baud counter plus 10-bit shift register.
// The line is registered, so it trails the internal bit timing by one cycle.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       bit_end,
    output logic [3:0] bit_idx
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0]         baud_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  active;

    assign busy    = active;
    assign bit_end = active && (baud_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx       <= 1'b1;
            active   <= 1'b0;
            shreg    <= '1;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            tx <= active ? shreg[0] : 1'b1;
            if (load) begin
                shreg    <= {1'b1, data, 1'b0};
                active   <= 1'b1;
                baud_cnt <= '0;
                bit_idx  <= '0;
            end else if (active) begin
                if (bit_end) begin
                    baud_cnt <= '0;
                    shreg    <= {1'b1, shreg[FRAME_BITS-1:1]};
                    if (bit_idx == 4'(FRAME_BITS - 1)) begin
                        active  <= 1'b0;
                        bit_idx <= '0;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/rom_uart_sender.sv
// Reads MSG_LEN bytes from a 1-cycle-latency ROM and sends each as an 8N1 frame.
// Start/abort/done sequencing lives here; bit timing lives in uart_tx_frame.
module rom_uart_sender #(
    parameter int CLK_FREQ = 27_000_000,
    parameter int BAUD     = 115_200,
    parameter int MSG_LEN  = 14,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [7:0]        rom_dout,
    output logic              uart_tx,
    output logic              busy,
    output logic              done
);
    import uart_pkg::*;

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);

    if (MSG_LEN < 1 || MSG_LEN > 2**ADDR_W) begin : g_bad_len
        $error("rom_uart_sender: MSG_LEN out of range 1..2**ADDR_W");
    end
    if (CPB < 2) begin : g_bad_baud
        $error("rom_uart_sender: CLK_FREQ/BAUD must be at least 2");
    end

    state_t            state, state_next;
    logic [ADDR_W-1:0] idx;
    logic              abort_flag;
    logic              last_byte;
    logic              f_busy, f_bit_end, f_load;
    logic [3:0]        f_bit_idx;

    assign last_byte = (idx == ADDR_W'(MSG_LEN - 1));
    assign f_load    = (state == WAIT) && !f_busy;
    assign rom_ce    = (state == FETCH);
    assign rom_oce   = 1'b1;
    assign rom_ad    = idx;

    uart_tx_frame #(.CLKS_PER_BIT(CPB)) u_frame (
        .clk     (clk),
        .reset   (reset),
        .load    (f_load),
        .data    (rom_dout),
        .tx      (uart_tx),
        .busy    (f_busy),
        .bit_end (f_bit_end),
        .bit_idx (f_bit_idx)
    );

    // START/DATA/STOP follow the frame's bit index so the FSM mirrors the line.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = WAIT;
            WAIT:    state_next = START;
            START:   if (f_bit_end) state_next = DATA;
            DATA:    if (f_bit_end && f_bit_idx == 4'd8) state_next = STOP;
            STOP:    if (f_bit_end) state_next = (last_byte || abort_flag) ? FINISH : FETCH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            abort_flag <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == FINISH);

            if (state == IDLE && start)
                idx <= '0;
            else if (state == STOP && state_next == FETCH)
                idx <= idx + ADDR_W'(1);

            if (state == IDLE)
                abort_flag <= 1'b0;
            else if (abort)
                abort_flag <= 1'b1;

            // busy drops the cycle after the done pulse unless a new start lands then
            if (state == IDLE && start)
                busy <= 1'b1;
            else if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rom_uart_sender.sv
// Bench for rom_uart_sender: three instances (MSG_LEN 14, 1, 16) at 10 clocks per bit,
// each with a 1-cycle ROM model and a line decoder, checked against a timing/byte model.
module tb_rom_uart_sender;

    localparam int CPB  = 10;
    localparam int P    = 10 * CPB + 2;
    localparam int MAXC = 4096;
    localparam int LENS [3] = '{14, 1, 16};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] start_v = '0;
    logic [2:0] abort_v = '0;
    logic [2:0] txv, busyv, donev, cev, ocev;
    logic [3:0] adv   [3];
    logic [7:0] doutv [3];

    logic [7:0] rom_img [16];
    logic [7:0] rxq [3][$];
    int         ferr [3];

    logic       tr_tx [MAXC];
    logic       tr_busy [MAXC];
    logic       tr_done [MAXC];
    logic       tr_ce [MAXC];
    logic [3:0] tr_ad [MAXC];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rom_uart_sender #(
            .CLK_FREQ (100),
            .BAUD     (10),
            .MSG_LEN  (LENS[g]),
            .ADDR_W   (4)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start_v[g]),
            .abort    (abort_v[g]),
            .rom_ce   (cev[g]),
            .rom_oce  (ocev[g]),
            .rom_ad   (adv[g]),
            .rom_dout (doutv[g]),
            .uart_tx  (txv[g]),
            .busy     (busyv[g]),
            .done     (donev[g])
        );

        always @(posedge clk) if (cev[g]) doutv[g] <= rom_img[adv[g]];

        // Line decoder: samples mid-cycle, roughly mid-bit.
        initial begin
            logic [7:0] by;
            ferr[g] = 0;
            forever begin
                @(negedge clk);
                if (!reset && txv[g] === 1'b0) begin
                    repeat (4) @(negedge clk);
                    if (txv[g] !== 1'b0) ferr[g]++;
                    for (int b = 0; b < 8; b++) begin
                        repeat (CPB) @(negedge clk);
                        by[b] = txv[g];
                    end
                    repeat (CPB) @(negedge clk);
                    if (txv[g] !== 1'b1) ferr[g]++;
                    rxq[g].push_back(by);
                end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected line level k cycles after the start edge for an n-byte message.
    function automatic logic exp_tx(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            int f = 3 + i * P;
            if (k >= f && k < f + 10 * CPB) begin
                int b = (k - f) / CPB;
                if (b == 0) return 1'b0;
                if (b == 9) return 1'b1;
                return rom_img[i][b-1];
            end
        end
        return 1'b1;
    endfunction

    // Pulse start and record outputs every cycle until done+3 or stop_at.
    task automatic go(input int id, input int hold, input int extra_at, input int abort_at,
                      input int stop_at, output int done_at, output int ncyc);
        done_at = -1;
        ncyc    = 0;
        @(negedge clk);
        start_v[id] = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < MAXC; k++) begin
            tr_tx[k]   = txv[id];
            tr_busy[k] = busyv[id];
            tr_done[k] = donev[id];
            tr_ce[k]   = cev[id];
            tr_ad[k]   = adv[id];
            ncyc = k + 1;
            if (donev[id] === 1'b1 && done_at < 0) done_at = k;
            if (k + 1 >= hold) start_v[id] = 1'b0;
            if (k == extra_at) start_v[id] = 1'b1;
            abort_v[id] = (k == abort_at);
            if (k == stop_at || (done_at >= 0 && k >= done_at + 3)) begin
                start_v[id] = 1'b0;
                abort_v[id] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_msg(input string tag, input int id, input int n, input int done_at, input int ncyc);
        int d = 3 + n * 10 * CPB + (n - 1) * 2;
        int e_tx = 0, e_busy = 0, e_done = 0, e_ce = 0, e_ad = 0, n_ce = 0;
        int m;
        for (int k = 0; k < ncyc; k++) begin
            logic ce_exp = (k % P == 0) && (k / P < n);
            if (tr_tx[k] !== exp_tx(k, n)) e_tx++;
            if (tr_busy[k] !== (k <= d)) e_busy++;
            if (tr_done[k] !== (k == d)) e_done++;
            if (tr_ce[k] !== ce_exp) e_ce++;
            if (ce_exp && tr_ad[k] !== 4'(k / P)) e_ad++;
            if (tr_ce[k] === 1'b1) n_ce++;
        end
        chk({tag, " done_cycle"}, done_at, d);
        chk({tag, " tx_trace_errs"}, e_tx, 0);
        chk({tag, " busy_trace_errs"}, e_busy, 0);
        chk({tag, " done_trace_errs"}, e_done, 0);
        chk({tag, " rom_ce_trace_errs"}, e_ce, 0);
        chk({tag, " rom_ad_errs"}, e_ad, 0);
        chk({tag, " rom_ce_count"}, n_ce, n);
        chk({tag, " rx_bytes"}, rxq[id].size(), n);
        m = (rxq[id].size() < n) ? rxq[id].size() : n;
        for (int i = 0; i < m; i++) chk($sformatf("%s rx_byte%0d", tag, i), int'(rxq[id][i]), int'(rom_img[i]));
        rxq[id].delete();
    endtask

    initial begin
        string s;
        int    da, nc, j, sa;

        s = "FPGA is fun!\r\n";
        for (int i = 0; i < 14; i++) rom_img[i] = s[i];
        rom_img[14] = 8'h00;
        rom_img[15] = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("reset tx%0d", g), int'(txv[g]), 1);
            chk($sformatf("reset busy%0d", g), int'(busyv[g]), 0);
            chk($sformatf("reset done%0d", g), int'(donev[g]), 0);
            chk($sformatf("reset ce%0d", g), int'(cev[g]), 0);
            chk($sformatf("reset ad%0d", g), int'(adv[g]), 0);
            chk($sformatf("reset oce%0d", g), int'(ocev[g]), 1);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // single start pulse, full message
        go(0, 1, -1, -1, MAXC, da, nc);
        check_msg("full", 0, 14, da, nc);

        // start held 50 cycles plus a stray pulse mid-message
        repeat ($urandom_range(1, 20)) @(posedge clk);
        go(0, 50, $urandom_range(60, 1300), -1, MAXC, da, nc);
        check_msg("held_start", 0, 14, da, nc);

        // abort during data bits of byte j: first byte 3 ("G"), then a random byte
        for (int r = 0; r < 2; r++) begin
            j = (r == 0) ? 2 : $urandom_range(0, 12);
            repeat ($urandom_range(1, 20)) @(posedge clk);
            go(0, 1, -1, 3 + j * P + CPB + $urandom_range(0, 8 * CPB - 2), MAXC, da, nc);
            check_msg($sformatf("abort_b%0d", j), 0, j + 1, da, nc);
            repeat ($urandom_range(1, 20)) @(posedge clk);
            go(0, 1, -1, -1, MAXC, da, nc);
            check_msg("after_abort", 0, 14, da, nc);
        end

        // asynchronous reset during data bits of byte 5
        repeat ($urandom_range(1, 20)) @(posedge clk);
        sa = 3 + 4 * P + CPB + $urandom_range(0, 8 * CPB - 2);
        go(0, 1, -1, -1, sa, da, nc);
        chk("pre_reset busy", int'(busyv[0]), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset tx", int'(txv[0]), 1);
        chk("async_reset busy", int'(busyv[0]), 0);
        chk("async_reset done", int'(donev[0]), 0);
        chk("async_reset ce", int'(cev[0]), 0);
        chk("async_reset ad", int'(adv[0]), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (150) @(negedge clk);
        rxq[0].delete();
        go(0, 1, -1, -1, MAXC, da, nc);
        check_msg("after_reset", 0, 14, da, nc);

        // one-byte and full-depth messages
        go(1, 1, -1, -1, MAXC, da, nc);
        check_msg("len1", 1, 1, da, nc);
        go(2, 1, -1, -1, MAXC, da, nc);
        check_msg("len16", 2, 16, da, nc);

        for (int g = 0; g < 3; g++) chk($sformatf("framing_errs%0d", g), ferr[g], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
